// File: rtl/fft_butterfly_add_stage_pipe.sv
// rtl/fft_butterfly_add_stage_pipe.sv - LANES-wide floating-point radix-2 butterfly a+b / a-b stage, 3-deep valid/ready pipeline
module fft_butterfly_add_stage_pipe #(
    parameter int EXP_BITS = 11,
    parameter int SIG_BITS = 52,
    parameter int LANES    = 2
) (
    input  logic                                   clk,
    input  logic                                   rst_n,
    input  logic                                   in_valid,
    output logic                                   in_ready,
    input  logic                                   in_halve,
    input  logic [LANES*(1+EXP_BITS+SIG_BITS)-1:0] a_re,
    input  logic [LANES*(1+EXP_BITS+SIG_BITS)-1:0] a_im,
    input  logic [LANES*(1+EXP_BITS+SIG_BITS)-1:0] b_re,
    input  logic [LANES*(1+EXP_BITS+SIG_BITS)-1:0] b_im,
    output logic                                   out_valid,
    input  logic                                   out_ready,
    output logic [LANES*(1+EXP_BITS+SIG_BITS)-1:0] sum_re,
    output logic [LANES*(1+EXP_BITS+SIG_BITS)-1:0] sum_im,
    output logic [LANES*(1+EXP_BITS+SIG_BITS)-1:0] dif_re,
    output logic [LANES*(1+EXP_BITS+SIG_BITS)-1:0] dif_im,
    input  logic                                   clr_flags,
    output logic                                   flag_ovf,
    output logic                                   flag_unf
);

    localparam int W  = 1 + EXP_BITS + SIG_BITS;
    localparam int M  = SIG_BITS + 1;
    localparam int G  = 3;
    localparam int AW = M + G;
    localparam int RW = AW + 1;
    localparam int EW = EXP_BITS + 2;
    localparam int NP = 2 * LANES;

    localparam logic [EXP_BITS-1:0] AW_E   = EXP_BITS'(AW);
    localparam logic signed [EW-1:0] ZERO_S = '0;
    localparam logic signed [EW-1:0] ONE_S  = EW'(1);
    localparam logic signed [EW-1:0] EMAX_S = EW'((2 ** EXP_BITS) - 1);

    // Larger-magnitude operand x, smaller y aligned to x with G guard bits plus a sticky bit.
    typedef struct packed {
        logic [EXP_BITS-1:0] e;
        logic [M-1:0]        mx;
        logic [AW-1:0]       my;
        logic                stk;
        logic                sx;
        logic                sy;
        logic                swp;
    } s1_t;

    typedef struct packed {
        logic                s;
        logic                z;
        logic [EW-1:0]       e;
        logic [SIG_BITS-1:0] f;
    } nrm_t;

    typedef struct packed {
        logic [W-1:0] w;
        logic         ovf;
        logic         unf;
    } res_t;

    function automatic s1_t denorm(input logic [W-1:0] a, input logic [W-1:0] b);
        s1_t                 r;
        logic [EXP_BITS-1:0] ea, eb, ed;
        logic [M-1:0]        ma, mb, ms;
        logic [2*AW-1:0]     sh;
        logic                a_big;
        ea    = a[W-2:SIG_BITS];
        eb    = b[W-2:SIG_BITS];
        ma    = (ea == '0) ? '0 : {1'b1, a[SIG_BITS-1:0]};
        mb    = (eb == '0) ? '0 : {1'b1, b[SIG_BITS-1:0]};
        a_big = {ea, ma} >= {eb, mb};
        r.swp = !a_big;
        r.e   = a_big ? ea : eb;
        r.mx  = a_big ? ma : mb;
        ms    = a_big ? mb : ma;
        ed    = a_big ? ea - eb : eb - ea;
        r.sx  = a_big ? a[W-1] : b[W-1];
        r.sy  = a_big ? b[W-1] : a[W-1];
        sh    = '0;
        if (ed >= AW_E) begin
            r.my  = '0;
            r.stk = |ms;
        end else begin
            sh    = {ms, {G{1'b0}}, {AW{1'b0}}} >> ed;
            r.my  = sh[2*AW-1:AW];
            r.stk = |sh[AW-1:0];
        end
        return r;
    endfunction

    // neg selects a-b: flips y's sign; when x was b the result sign flips too.
    // Subtracting the sticky keeps truncation toward zero exact on the effective-subtract path.
    function automatic nrm_t addsub(input s1_t p, input logic neg);
        nrm_t          r;
        logic          effsub;
        logic [RW-1:0] x, y, sum, sn;
        int            lead;
        effsub = p.sx ^ p.sy ^ neg;
        x      = {1'b0, p.mx, {G{1'b0}}};
        y      = {1'b0, p.my};
        sum    = effsub ? (x - y - RW'(p.stk)) : (x + y);
        lead   = 0;
        for (int i = 0; i < RW; i++) begin
            if (sum[i]) lead = i;
        end
        sn  = sum << (RW - 1 - lead);
        r.z = (sum == '0);
        r.s = r.z ? 1'b0 : (p.sx ^ (neg & p.swp));
        r.e = r.z ? '0 : (EW'({2'b00, p.e}) + EW'(lead) - EW'(RW - 2));
        r.f = r.z ? '0 : sn[RW-2 -: SIG_BITS];
        return r;
    endfunction

    function automatic res_t finish(input nrm_t n, input logic halve);
        res_t                  r;
        logic signed [EW-1:0]  e;
        e = $signed(n.e);
        if (halve && !n.z) e = e - ONE_S;
        r.ovf = 1'b0;
        r.unf = 1'b0;
        if (n.z) begin
            r.w = '0;
        end else if (e <= ZERO_S) begin
            r.w   = {n.s, {(W-1){1'b0}}};
            r.unf = 1'b1;
        end else if (e >= EMAX_S) begin
            r.w   = {n.s, {(EXP_BITS-1){1'b1}}, 1'b0, {SIG_BITS{1'b1}}};
            r.ovf = 1'b1;
        end else begin
            r.w = {n.s, e[EXP_BITS-1:0], n.f};
        end
        return r;
    endfunction

    logic v1, v2, v3, h1, h2;
    logic en1, en2, en3;
    logic [NP-1:0] ovf_vec, unf_vec;

    assign en3       = !v3 || out_ready;
    assign en2       = !v2 || en3;
    assign en1       = !v1 || en2;
    assign in_ready  = en1;
    assign out_valid = v3;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1 <= 1'b0;
            v2 <= 1'b0;
            v3 <= 1'b0;
            h1 <= 1'b0;
            h2 <= 1'b0;
        end else begin
            if (en1) begin
                v1 <= in_valid;
                if (in_valid) h1 <= in_halve;
            end
            if (en2) begin
                v2 <= v1;
                if (v1) h2 <= h1;
            end
            if (en3) v3 <= v2;
        end
    end

    // Status follows the beat actually handed to the consumer; a same-cycle set beats the clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            flag_ovf <= 1'b0;
            flag_unf <= 1'b0;
        end else begin
            flag_ovf <= (flag_ovf && !clr_flags) || (out_valid && out_ready && |ovf_vec);
            flag_unf <= (flag_unf && !clr_flags) || (out_valid && out_ready && |unf_vec);
        end
    end

    for (genvar p = 0; p < NP; p++) begin : g_part
        localparam int L = p / 2;
        logic [W-1:0] a_w, b_w, o_sum, o_dif;
        logic         o_ovf, o_unf;
        s1_t          s1_d, s1_q;
        nrm_t         ns_d, nd_d, ns_q, nd_q;
        res_t         rs, rd;

        if (p % 2 == 0) begin : g_re
            assign a_w = a_re[L*W +: W];
            assign b_w = b_re[L*W +: W];
            assign sum_re[L*W +: W] = o_sum;
            assign dif_re[L*W +: W] = o_dif;
        end else begin : g_im
            assign a_w = a_im[L*W +: W];
            assign b_w = b_im[L*W +: W];
            assign sum_im[L*W +: W] = o_sum;
            assign dif_im[L*W +: W] = o_dif;
        end

        assign s1_d = denorm(a_w, b_w);
        assign ns_d = addsub(s1_q, 1'b0);
        assign nd_d = addsub(s1_q, 1'b1);
        assign rs   = finish(ns_q, h2);
        assign rd   = finish(nd_q, h2);

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                s1_q  <= '0;
                ns_q  <= '0;
                nd_q  <= '0;
                o_sum <= '0;
                o_dif <= '0;
                o_ovf <= 1'b0;
                o_unf <= 1'b0;
            end else begin
                if (en1 && in_valid) s1_q <= s1_d;
                if (en2 && v1) begin
                    ns_q <= ns_d;
                    nd_q <= nd_d;
                end
                if (en3 && v2) begin
                    o_sum <= rs.w;
                    o_dif <= rd.w;
                    o_ovf <= rs.ovf | rd.ovf;
                    o_unf <= rs.unf | rd.unf;
                end
            end
        end

        assign ovf_vec[p] = o_ovf;
        assign unf_vec[p] = o_unf;
    end

endmodule

// File: tb/tb_fft_butterfly_add_stage_pipe.sv
// tb/tb_fft_butterfly_add_stage_pipe.sv - self-checking bench for fft_butterfly_add_stage_pipe (EXP_BITS=11, SIG_BITS=52, LANES=2)
module tb_fft_butterfly_add_stage_pipe;

    typedef struct packed {
        logic [127:0] are;
        logic [127:0] aim;
        logic [127:0] bre;
        logic [127:0] bim;
        logic         h;
    } beat_t;

    localparam logic [63:0] FMAX = 64'h7FEFFFFFFFFFFFFF;

    logic         clk, rst_n, in_valid, in_ready, in_halve, out_valid, out_ready;
    logic         clr_flags, flag_ovf, flag_unf;
    logic [127:0] a_re, a_im, b_re, b_im, sum_re, sum_im, dif_re, dif_im;

    int    checks = 0;
    int    errors = 0;
    beat_t stim_q[$];
    logic [511:0] exp_q[$];
    bit    acc_ovf, acc_unf;

    fft_butterfly_add_stage_pipe #(.EXP_BITS(11), .SIG_BITS(52), .LANES(2)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_halve(in_halve),
        .a_re(a_re), .a_im(a_im), .b_re(b_re), .b_im(b_im),
        .out_valid(out_valid), .out_ready(out_ready),
        .sum_re(sum_re), .sum_im(sum_im), .dif_re(dif_re), .dif_im(dif_im),
        .clr_flags(clr_flags), .flag_ovf(flag_ovf), .flag_unf(flag_unf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Exact signed-integer sum in units of the smaller exponent, then truncate, halve, flush/saturate.
    function automatic logic [63:0] ref_part(input logic [63:0] a, input logic [63:0] b,
                                             input bit sub, input bit h, output bit ovf, output bit unf);
        int ea, eb, emin, p, e;
        logic signed [255:0] va, vb, s;
        logic [255:0] mag, mant;
        bit neg;
        ovf = 0;
        unf = 0;
        ea = int'(a[62:52]);
        eb = int'(b[62:52]);
        if (ea == 0 && eb == 0) return 64'h0;
        emin = (ea == 0) ? eb : (eb == 0) ? ea : (ea < eb ? ea : eb);
        va = '0;
        vb = '0;
        if (ea != 0) begin
            va = {1'b1, a[51:0]};
            va = va <<< (ea - emin);
            if (a[63]) va = -va;
        end
        if (eb != 0) begin
            vb = {1'b1, b[51:0]};
            vb = vb <<< (eb - emin);
            if (b[63] ^ sub) vb = -vb;
        end
        s = va + vb;
        if (s == 0) return 64'h0;
        neg = (s < 0);
        mag = neg ? -s : s;
        p = 0;
        for (int i = 0; i < 256; i++) if (mag[i]) p = i;
        e = emin + p - 52;
        mant = (p >= 52) ? (mag >> (p - 52)) : (mag << (52 - p));
        if (h) e = e - 1;
        if (e <= 0) begin
            unf = 1;
            return {neg, 63'h0};
        end
        if (e >= 2047) begin
            ovf = 1;
            return {neg, FMAX[62:0]};
        end
        return {neg, 11'(e), mant[51:0]};
    endfunction

    function automatic logic [511:0] ref_beat(input beat_t bt, output bit ovf, output bit unf);
        logic [127:0] sre, sim, dre, dim;
        bit o, u;
        ovf = 0;
        unf = 0;
        for (int l = 0; l < 2; l++) begin
            sre[l*64 +: 64] = ref_part(bt.are[l*64 +: 64], bt.bre[l*64 +: 64], 0, bt.h, o, u); ovf |= o; unf |= u;
            sim[l*64 +: 64] = ref_part(bt.aim[l*64 +: 64], bt.bim[l*64 +: 64], 0, bt.h, o, u); ovf |= o; unf |= u;
            dre[l*64 +: 64] = ref_part(bt.are[l*64 +: 64], bt.bre[l*64 +: 64], 1, bt.h, o, u); ovf |= o; unf |= u;
            dim[l*64 +: 64] = ref_part(bt.aim[l*64 +: 64], bt.bim[l*64 +: 64], 1, bt.h, o, u); ovf |= o; unf |= u;
        end
        return {sre, sim, dre, dim};
    endfunction

    function automatic logic [63:0] rnd_fp(input int base);
        logic [63:0] r;
        r[63]    = 1'($urandom_range(0, 1));
        r[51:0]  = 52'({$urandom, $urandom});
        r[62:52] = ($urandom_range(0, 11) == 0) ? 11'h0 : 11'(base + int'($urandom_range(0, 80)) - 40);
        return r;
    endfunction

    function automatic beat_t rnd_beat();
        beat_t b;
        int base;
        for (int l = 0; l < 2; l++) begin
            base = int'($urandom_range(60, 1960));
            b.are[l*64 +: 64] = rnd_fp(base);
            b.bre[l*64 +: 64] = rnd_fp(base);
            base = int'($urandom_range(60, 1960));
            b.aim[l*64 +: 64] = rnd_fp(base);
            b.bim[l*64 +: 64] = rnd_fp(base);
        end
        case ($urandom_range(0, 7))
            0: b.bre[63:0] = b.are[63:0];
            1: b.bim[127:64] = b.aim[127:64] ^ {1'b1, 63'h0};
            2: b.bre[126:116] = b.are[126:116];
            default: ;
        endcase
        b.h = 1'($urandom_range(0, 1));
        return b;
    endfunction

    task automatic drive(input beat_t b);
        a_re = b.are; a_im = b.aim; b_re = b.bre; b_im = b.bim; in_halve = b.h;
    endtask

    task automatic pulse_clr();
        @(negedge clk); clr_flags = 1'b1;
        @(negedge clk); clr_flags = 1'b0;
    endtask

    task automatic single(input beat_t bt, output logic [511:0] res, output int lat);
        @(negedge clk);
        drive(bt); in_valid = 1'b1; out_ready = 1'b1;
        #1 check("single_in_ready", in_ready, 1);
        @(negedge clk);
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 10) begin
            @(negedge clk);
            lat++;
        end
        res = {sum_re, sum_im, dif_re, dif_im};
    endtask

    // pat 0: out_ready=1, 1: 1,0,0,1 repeating, 2: random
    task automatic run_stream(input int pat);
        int cyc = 0;
        bit accepted = 0, stalled = 0, o, u;
        logic [511:0] held = '0, obs;
        while ((stim_q.size() > 0 || exp_q.size() > 0) && cyc < 2000) begin
            @(negedge clk);
            out_ready = (pat == 0) ? 1'b1 : (pat == 1) ? ((cyc % 4 == 0) || (cyc % 4 == 3)) : 1'($urandom_range(0, 1));
            if (accepted) in_valid = 1'b0;
            accepted = 0;
            if (!in_valid && stim_q.size() > 0) begin
                drive(stim_q[0]);
                in_valid = 1'b1;
            end
            #1;
            obs = {sum_re, sum_im, dif_re, dif_im};
            check("in_ready", in_ready, !(exp_q.size() == 3 && !out_ready));
            if (stalled) begin
                check("stall_valid", out_valid, 1);
                check("stall_data", obs, held);
            end
            stalled = 0;
            if (out_valid) begin
                if (out_ready) begin
                    if (exp_q.size() == 0) check("spurious_beat", 1, 0);
                    else check("stream_data", obs, exp_q.pop_front());
                end else begin
                    stalled = 1;
                    held = obs;
                end
            end
            if (in_valid && in_ready) begin
                exp_q.push_back(ref_beat(stim_q.pop_front(), o, u));
                acc_ovf |= o;
                acc_unf |= u;
                accepted = 1;
            end
            cyc++;
        end
        if (cyc >= 2000) check("stream_timeout", cyc, 0);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    initial begin
        beat_t bt;
        logic [511:0] res;
        int lat;
        rst_n = 1'b0; in_valid = 1'b0; in_halve = 1'b0; out_ready = 1'b0; clr_flags = 1'b0;
        a_re = '0; a_im = '0; b_re = '0; b_im = '0;
        repeat (2) @(negedge clk);
        check("rst_out_valid", out_valid, 0);
        check("rst_flags", {flag_ovf, flag_unf}, 0);
        check("rst_data", {sum_re, sum_im, dif_re, dif_im}, 0);
        rst_n = 1'b1;
        #1 check("rst_in_ready", in_ready, 1);

        // 1+2i and 0.5-1i in both lanes
        bt.are = {2{64'h3FF0000000000000}}; bt.aim = {2{64'h4000000000000000}};
        bt.bre = {2{64'h3FE0000000000000}}; bt.bim = {2{64'hBFF0000000000000}};
        bt.h = 1'b0;
        single(bt, res, lat);
        check("latency", lat, 3);
        check("basic", res, {{2{64'h3FF8000000000000}}, {2{64'h3FF0000000000000}},
                             {2{64'h3FE0000000000000}}, {2{64'h4008000000000000}}});
        bt.h = 1'b1;
        single(bt, res, lat);
        check("halve", res, {{2{64'h3FE8000000000000}}, {2{64'h3FE0000000000000}},
                             {2{64'h3FD0000000000000}}, {2{64'h3FF8000000000000}}});
        repeat (2) @(negedge clk);
        check("halve_flags", {flag_ovf, flag_unf}, 0);

        pulse_clr();
        acc_ovf = 0; acc_unf = 0;
        for (int i = 0; i < 20; i++) stim_q.push_back(rnd_beat());
        run_stream(1);
        repeat (2) @(negedge clk);
        check("toggle_flags", {flag_ovf, flag_unf}, {acc_ovf, acc_unf});

        pulse_clr();
        acc_ovf = 0; acc_unf = 0;
        for (int i = 0; i < 60; i++) stim_q.push_back(rnd_beat());
        run_stream(2);
        repeat (2) @(negedge clk);
        check("random_flags", {flag_ovf, flag_unf}, {acc_ovf, acc_unf});

        pulse_clr();
        bt = '0;
        bt.are = {64'h0, FMAX}; bt.bre = {64'h0, FMAX};
        single(bt, res, lat);
        check("ovf_data", res, {64'h0, FMAX, 128'h0, 128'h0, 128'h0});
        @(negedge clk);
        check("ovf_set", flag_ovf, 1);
        repeat (3) @(negedge clk);
        check("ovf_sticky", flag_ovf, 1);
        pulse_clr();
        #1 check("ovf_clear", flag_ovf, 0);
        single(bt, res, lat);
        clr_flags = 1'b1;
        @(negedge clk);
        clr_flags = 1'b0;
        check("ovf_set_wins", flag_ovf, 1);

        pulse_clr();
        bt = '0;
        bt.are = {64'h0, 64'h0010000000000000}; bt.h = 1'b1;
        single(bt, res, lat);
        check("unf_data", res, 512'h0);
        @(negedge clk);
        check("unf_flags", {flag_ovf, flag_unf}, 2'b01);

        @(negedge clk);
        out_ready = 1'b0;
        drive(rnd_beat()); in_valid = 1'b1;
        repeat (3) begin
            @(negedge clk);
            drive(rnd_beat());
        end
        #1;
        check("full_in_ready", in_ready, 0);
        check("full_out_valid", out_valid, 1);
        in_valid = 1'b0;
        rst_n = 1'b0;
        #1 check("midrst_out_valid", out_valid, 0);
        @(negedge clk);
        rst_n = 1'b1; out_ready = 1'b1;
        #1 check("midrst_in_ready", in_ready, 1);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check("midrst_no_stale", out_valid, 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
